// File: rtl/clk_div_bank.sv
// Multi-channel 50%-duty clock divider with a runtime divisor per channel.
// Divisor and enable changes only take effect at period boundaries.

module clk_buf (
  input  logic a,
  output logic y
);
  assign y = a;
endmodule

module clk_div_bank #(
  parameter int unsigned CHNL_NUM  = 4,
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned DIV_RST   = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CHNL_NUM-1:0]           en_i,
  input  logic [CHNL_NUM*DIV_WIDTH-1:0] div_i,
  input  logic [CHNL_NUM-1:0]           div_valid_i,
  output logic [CHNL_NUM-1:0]           div_ready_o,
  output logic [CHNL_NUM-1:0]           clk_o,
  output logic [CHNL_NUM-1:0]           tick_o,
  output logic [CHNL_NUM-1:0]           busy_o
);

  typedef enum logic {IDLE, RUN} state_t;

  for (genvar c = 0; c < CHNL_NUM; c++) begin : g_ch
    state_t               state, state_nx;
    logic [DIV_WIDTH-1:0] cur_div, cur_div_nx;
    logic [DIV_WIDTH-1:0] shadow, shadow_nx;
    logic [DIV_WIDTH-1:0] cnt, cnt_nx;
    logic                 pend, pend_nx;
    logic                 clk_q, clk_nx;
    logic                 tick_q, tick_nx;
    logic                 apply;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state   <= IDLE;
        cur_div <= DIV_WIDTH'(DIV_RST);
        shadow  <= DIV_WIDTH'(DIV_RST);
        pend    <= 1'b0;
        cnt     <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state   <= state_nx;
        cur_div <= cur_div_nx;
        shadow  <= shadow_nx;
        pend    <= pend_nx;
        cnt     <= cnt_nx;
        clk_q   <= clk_nx;
        tick_q  <= tick_nx;
      end
    end

    always_comb begin
      state_nx   = state;
      cur_div_nx = cur_div;
      shadow_nx  = shadow;
      pend_nx    = pend;
      cnt_nx     = cnt;
      clk_nx     = clk_q;
      tick_nx    = 1'b0;
      apply      = 1'b0;
      case (state)
        IDLE: begin
          clk_nx = 1'b0;
          cnt_nx = '0;
          if (en_i[c]) begin
            apply    = 1'b1;
            clk_nx   = 1'b1;
            tick_nx  = 1'b1;
            state_nx = RUN;
          end
        end
        RUN: begin
          if (cnt != cur_div) begin
            cnt_nx = cnt + 1'b1;
          end else begin
            cnt_nx = '0;
            if (clk_q) begin
              clk_nx = 1'b0;
            end else if (!en_i[c]) begin
              state_nx = IDLE;
            end else begin
              apply   = 1'b1;
              clk_nx  = 1'b1;
              tick_nx = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
      // Apply uses the registered pending flag, so a same-edge transfer waits for the next boundary.
      if (apply && pend) begin
        cur_div_nx = shadow;
        pend_nx    = 1'b0;
      end
      if (div_valid_i[c] && !pend) begin
        shadow_nx = div_i[c*DIV_WIDTH +: DIV_WIDTH];
        pend_nx   = 1'b1;
      end
    end

    assign div_ready_o[c] = ~pend;
    assign busy_o[c]      = (state == RUN);
    assign tick_o[c]      = tick_q;

    clk_buf u_buf (
      .a (clk_q),
      .y (clk_o[c])
    );
  end

endmodule
